// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory port arbiter: FSM state encoding,
// address-mux select values and counter width.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_e;

    localparam logic SEL_PC   = 1'b0;
    localparam logic SEL_DATA = 1'b1;

    localparam int unsigned CNT_W = 4;

    // Increment that sticks at the ceiling instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] ceil);
        return (v >= ceil) ? ceil : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared memory port between instruction fetch and data access,
// sequencing fixed-latency transactions with data priority and an IF starvation guard.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned MAX_CONSEC  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic d_req,
    input  logic d_we,
    output logic sel,
    output logic mem_en,
    output logic mem_we,
    output logic if_done,
    output logic d_done,
    output logic busy
);

    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] CONSEC_MAX = CNT_W'(MAX_CONSEC);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] consec_q, consec_d;
    logic             wr_q, wr_d;

    logic final_cycle;
    logic arbitrate;
    logic if_elig;
    logic d_elig;
    logic d_wins;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
        state_d  = state_q;
        cnt_d    = cnt_q;
        consec_d = consec_q;
        wr_d     = wr_q;

        final_cycle = (state_q != IDLE) && (cnt_q == LAST_CNT);
        arbitrate   = (state_q == IDLE) || final_cycle;

        // The requester finishing this cycle still holds its req; it must not re-win immediately.
        if_elig = if_req && !(final_cycle && state_q == BUSY_IF);
        d_elig  = d_req  && !(final_cycle && state_q == BUSY_D);
        d_wins  = d_elig && !(if_elig && consec_q == CONSEC_MAX);

        if (arbitrate) begin
            cnt_d = '0;
            if (d_wins) begin
                state_d  = BUSY_D;
                wr_d     = d_we;
                consec_d = if_elig ? sat_inc(consec_q, CONSEC_MAX) : '0;
            end else if (if_elig) begin
                state_d  = BUSY_IF;
                consec_d = '0;
            end else begin
                state_d  = IDLE;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Outputs are registered from the next state so they are glitch-free and
    // cleared by the asynchronous reset together with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            consec_q <= '0;
            wr_q     <= 1'b0;
            sel      <= SEL_PC;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            if_done  <= 1'b0;
            d_done   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            consec_q <= consec_d;
            wr_q     <= wr_d;
            sel      <= (state_d == BUSY_D) ? SEL_DATA : SEL_PC;
            mem_en   <= (state_d != IDLE);
            busy     <= (state_d != IDLE);
            mem_we   <= (state_d == BUSY_D) && wr_d;
            if_done  <= (state_d == BUSY_IF) && (cnt_d == LAST_CNT);
            d_done   <= (state_d == BUSY_D)  && (cnt_d == LAST_CNT);
        end
    end

endmodule
